// File: rtl/mcu_trigger_spi_slave.sv
// mcu_trigger_spi_slave: drum-hit event FIFO served to the MCU over mode-0 SPI.
// Define TIMESTAMP_EN for 32-bit frames carrying a prescaled push timestamp.
module mcu_trigger_spi_slave #(
  parameter int          FIFO_DEPTH  = 8,
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] FLUSH_CMD   = 16'hFFFF
) (
  input  logic                        clk,
  input  logic                        fpga_rst_n,
  input  logic                        trig_valid,
  input  logic [3:0]                  trig_drum_id,
  input  logic [6:0]                  trig_velocity,
  input  logic                        mcu_sck,
  input  logic                        mcu_sdi,
  input  logic                        mcu_load,
  output logic                        mcu_sdo,
  output logic                        mcu_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow_led
);
  localparam int AW = $clog2(FIFO_DEPTH);
`ifdef TIMESTAMP_EN
  localparam int FW = 32;
  localparam int EW = 30;
`else
  localparam int FW = 16;
  localparam int EW = 14;
`endif
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STAGED = 2'd1;
  localparam logic [1:0] SHIFT  = 2'd2;
  localparam logic [5:0] FW_L   = 6'(FW);
  localparam logic [AW:0] FULL_L = (AW+1)'(FIFO_DEPTH);

  logic [SYNC_STAGES-1:0] sck_sync, sdi_sync, load_sync;
  logic sck_s, sdi_s, load_s, sck_d, load_d;
  logic sck_rise, sck_fall, load_rise, load_fall;

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [2:0]    seq;
  logic full, empty, push, pop, flush, drop;
  logic [EW-1:0] entry_in, head;
  logic [FW-1:0] frame;

  logic [1:0]    state;
  logic [FW-1:0] tx_shift;
  logic [15:0]   rx_shift;
  logic [5:0]    bit_cnt;
  logic tx_valid, tx_ovf, ovf_new, pend_ovf;
  logic xfer_end, complete;

  assign sck_s     = sck_sync[SYNC_STAGES-1];
  assign sdi_s     = sdi_sync[SYNC_STAGES-1];
  assign load_s    = load_sync[SYNC_STAGES-1];
  assign sck_rise  = sck_s & ~sck_d;
  assign sck_fall  = ~sck_s & sck_d;
  assign load_rise = load_s & ~load_d;
  assign load_fall = ~load_s & load_d;

  assign full     = (count == FULL_L);
  assign empty    = (count == '0);
  assign xfer_end = (state == SHIFT) && load_fall;
  assign complete = xfer_end && (bit_cnt == FW_L);
  assign flush    = complete && (rx_shift == FLUSH_CMD);
  assign pop      = complete && !flush && tx_valid;
  assign push     = trig_valid && (!full || pop || flush);
  assign drop     = trig_valid && !push;
  assign head     = mem[rd_ptr];
  assign fifo_level = count;

`ifdef TIMESTAMP_EN
  logic [25:0] ts_cnt;

  // Free-running cycle counter; upper 16 bits are the 2^10-prescaled stamp
  always_ff @(posedge clk or negedge fpga_rst_n) begin
    if (!fpga_rst_n) ts_cnt <= '0;
    else             ts_cnt <= ts_cnt + 1'b1;
  end

  assign entry_in = {ts_cnt[25:10], trig_drum_id, trig_velocity, seq};
  assign frame    = {head[EW-1:14], 1'b1, pend_ovf, head[13:0]};
`else
  assign entry_in = {trig_drum_id, trig_velocity, seq};
  assign frame    = {1'b1, pend_ovf, head};
`endif

  // Bring the SPI pins into the clk domain and keep one cycle of history
  always_ff @(posedge clk or negedge fpga_rst_n) begin
    if (!fpga_rst_n) begin
      sck_sync  <= '0;
      sdi_sync  <= '0;
      load_sync <= '0;
      sck_d     <= 1'b0;
      load_d    <= 1'b0;
    end else begin
      sck_sync[0]  <= mcu_sck;
      sdi_sync[0]  <= mcu_sdi;
      load_sync[0] <= mcu_load;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sck_sync[i]  <= sck_sync[i-1];
        sdi_sync[i]  <= sdi_sync[i-1];
        load_sync[i] <= load_sync[i-1];
      end
      sck_d  <= sck_s;
      load_d <= load_s;
    end
  end

  // Event storage; contents need no reset since pointers gate reads
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= entry_in;
  end

  // Queue pointers, occupancy and sequence numbering
  always_ff @(posedge clk or negedge fpga_rst_n) begin
    if (!fpga_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      seq    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        seq    <= seq + 1'b1;
      end
      if (flush) begin
        rd_ptr <= wr_ptr;
        count  <= {{AW{1'b0}}, push};
      end else begin
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // Overflow tracking; ovf_new marks drops the in-flight frame missed
  always_ff @(posedge clk or negedge fpga_rst_n) begin
    if (!fpga_rst_n) begin
      pend_ovf     <= 1'b0;
      overflow_led <= 1'b0;
      ovf_new      <= 1'b0;
    end else begin
      if (flush) begin
        pend_ovf     <= 1'b0;
        overflow_led <= 1'b0;
      end else if (drop) begin
        pend_ovf     <= 1'b1;
        overflow_led <= 1'b1;
      end else if (pop && tx_ovf && !ovf_new) begin
        pend_ovf <= 1'b0;
      end
      if (state == SHIFT)
        ovf_new <= ovf_new | drop;
      else if (state == STAGED && load_rise)
        ovf_new <= drop;
      else
        ovf_new <= 1'b0;
    end
  end

  // Frame staging and SPI shift engine
  always_ff @(posedge clk or negedge fpga_rst_n) begin
    if (!fpga_rst_n) begin
      state    <= IDLE;
      tx_shift <= '0;
      rx_shift <= '0;
      bit_cnt  <= '0;
      tx_valid <= 1'b0;
      tx_ovf   <= 1'b0;
      mcu_sdo  <= 1'b0;
      mcu_done <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          mcu_done <= 1'b0;
          mcu_sdo  <= 1'b0;
          if (!empty) begin
            tx_shift <= frame;
            tx_valid <= 1'b1;
            tx_ovf   <= pend_ovf;
            mcu_sdo  <= frame[FW-1];
            state    <= STAGED;
          end else if (load_rise) begin
            tx_shift <= '0;
            tx_valid <= 1'b0;
            tx_ovf   <= 1'b0;
            rx_shift <= '0;
            bit_cnt  <= '0;
            state    <= SHIFT;
          end
        end
        STAGED: begin
          mcu_done     <= 1'b1;
          tx_shift[14] <= pend_ovf;
          tx_ovf       <= pend_ovf;
          if (load_rise) begin
            rx_shift <= '0;
            bit_cnt  <= '0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (load_fall) begin
            if (bit_cnt == FW_L) begin
              mcu_done <= 1'b0;
              mcu_sdo  <= 1'b0;
              state    <= IDLE;
            end else if (tx_valid) begin
              tx_shift <= frame;
              tx_ovf   <= pend_ovf;
              mcu_sdo  <= frame[FW-1];
              state    <= STAGED;
            end else begin
              mcu_sdo <= 1'b0;
              state   <= IDLE;
            end
          end else if (bit_cnt != FW_L) begin
            if (sck_rise) begin
              rx_shift <= {rx_shift[14:0], sdi_s};
              bit_cnt  <= bit_cnt + 1'b1;
            end
            if (sck_fall) begin
              tx_shift <= {tx_shift[FW-2:0], 1'b0};
              mcu_sdo  <= tx_shift[FW-2];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mcu_trigger_spi_slave.sv
// tb_mcu_trigger_spi_slave: directed checks of the trigger SPI slave.
// Each task drives one scenario against hand-computed frames.
module tb_mcu_trigger_spi_slave;
  logic       clk = 1'b0;
  logic       fpga_rst_n = 1'b0;
  logic       trig_valid = 1'b0;
  logic [3:0] trig_drum_id = '0;
  logic [6:0] trig_velocity = '0;
  logic       mcu_sck = 1'b0;
  logic       mcu_sdi = 1'b0;
  logic       mcu_load = 1'b0;
  logic       mcu_sdo;
  logic       mcu_done;
  logic [3:0] fifo_level;
  logic       overflow_led;

  int checks = 0;
  int failures = 0;

  mcu_trigger_spi_slave dut (
    .clk           (clk),
    .fpga_rst_n    (fpga_rst_n),
    .trig_valid    (trig_valid),
    .trig_drum_id  (trig_drum_id),
    .trig_velocity (trig_velocity),
    .mcu_sck       (mcu_sck),
    .mcu_sdi       (mcu_sdi),
    .mcu_load      (mcu_load),
    .mcu_sdo       (mcu_sdo),
    .mcu_done      (mcu_done),
    .fifo_level    (fifo_level),
    .overflow_led  (overflow_led)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    fpga_rst_n = 1'b0;
    trig_valid = 1'b0;
    mcu_sck = 1'b0;
    mcu_sdi = 1'b0;
    mcu_load = 1'b0;
    repeat (3) @(negedge clk);
    fpga_rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic push(input logic [3:0] id, input logic [6:0] vel);
    trig_drum_id = id;
    trig_velocity = vel;
    trig_valid = 1'b1;
    @(negedge clk);
    trig_valid = 1'b0;
  endtask

  task automatic spi_xfer(input logic [15:0] tx, input int nbits,
                          input bit push_end, output logic [15:0] rx);
    rx = '0;
    mcu_load = 1'b1;
    repeat (8) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      mcu_sdi = tx[15-i];
      repeat (4) @(negedge clk);
      rx = {rx[14:0], mcu_sdo};
      mcu_sck = 1'b1;
      repeat (4) @(negedge clk);
      mcu_sck = 1'b0;
    end
    repeat (8) @(negedge clk);
    mcu_load = 1'b0;
    if (push_end) begin
      @(negedge clk);
      @(negedge clk);
      trig_valid = 1'b1;
      @(negedge clk);
      trig_valid = 1'b0;
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({mcu_sdo, mcu_done, overflow_led} !== 3'b000 || fifo_level !== 4'd0) begin
      failures++;
      $display("FAIL reset: sdo=%b done=%b led=%b level=%0d, required all 0",
               mcu_sdo, mcu_done, overflow_led, fifo_level);
    end
  endtask

  task automatic test_single_event();
    logic [15:0] rx;
    do_reset();
    trig_drum_id = 4'd3;
    trig_velocity = 7'd100;
    trig_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    trig_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (mcu_done !== 1'b0) begin
      failures++;
      $display("FAIL done_early: done=%b required 0", mcu_done);
    end
    @(posedge clk);
    #1;
    checks++;
    if (mcu_done !== 1'b1) begin
      failures++;
      $display("FAIL done_latency: done=%b required 1", mcu_done);
    end
    @(negedge clk);
    spi_xfer(16'h0000, 16, 1'b0, rx);
    checks++;
    if (rx !== 16'h8F20) begin
      failures++;
      $display("FAIL single_frame: got %h required 8f20", rx);
    end
    checks++;
    if (mcu_done !== 1'b0 || fifo_level !== 4'd0) begin
      failures++;
      $display("FAIL single_after: done=%b level=%0d required 0/0",
               mcu_done, fifo_level);
    end
  endtask

  task automatic test_overflow();
    logic [15:0] rx;
    do_reset();
    for (int i = 0; i < 9; i++) push(4'd5, 7'd7);
    repeat (4) @(negedge clk);
    checks++;
    if (fifo_level !== 4'd8 || overflow_led !== 1'b1) begin
      failures++;
      $display("FAIL ovf_fill: level=%0d led=%b required 8/1",
               fifo_level, overflow_led);
    end
    for (int f = 0; f < 8; f++) begin
      spi_xfer(16'h0000, 16, 1'b0, rx);
      if (f == 0) begin
        checks++;
        if (rx !== 16'hD438) begin
          failures++;
          $display("FAIL ovf_frame1: got %h required d438", rx);
        end
      end
      if (f == 1) begin
        checks++;
        if (rx !== 16'h9439) begin
          failures++;
          $display("FAIL ovf_frame2: got %h required 9439", rx);
        end
      end
      if (f == 7) begin
        checks++;
        if (rx !== 16'h943F) begin
          failures++;
          $display("FAIL ovf_frame8: got %h required 943f", rx);
        end
      end
    end
    checks++;
    if (fifo_level !== 4'd0 || overflow_led !== 1'b1 || mcu_done !== 1'b0) begin
      failures++;
      $display("FAIL ovf_drain: level=%0d led=%b done=%b required 0/1/0",
               fifo_level, overflow_led, mcu_done);
    end
  endtask

  task automatic test_empty_read();
    logic [15:0] rx;
    do_reset();
    spi_xfer(16'h1234, 16, 1'b0, rx);
    checks++;
    if (rx !== 16'h0000 || mcu_done !== 1'b0 || fifo_level !== 4'd0) begin
      failures++;
      $display("FAIL empty_read: rx=%h done=%b level=%0d required 0000/0/0",
               rx, mcu_done, fifo_level);
    end
  endtask

  task automatic test_abort();
    logic [15:0] rx;
    do_reset();
    push(4'd2, 7'd1);
    push(4'd9, 7'd127);
    repeat (4) @(negedge clk);
    spi_xfer(16'h0000, 7, 1'b0, rx);
    checks++;
    if (rx[6:0] !== 7'h44 || fifo_level !== 4'd2 || mcu_done !== 1'b1) begin
      failures++;
      $display("FAIL abort: bits=%h level=%0d done=%b required 44/2/1",
               rx[6:0], fifo_level, mcu_done);
    end
    spi_xfer(16'h0000, 16, 1'b0, rx);
    checks++;
    if (rx !== 16'h8808) begin
      failures++;
      $display("FAIL abort_head: got %h required 8808", rx);
    end
    spi_xfer(16'h0000, 16, 1'b0, rx);
    checks++;
    if (rx !== 16'hA7F9 || fifo_level !== 4'd0) begin
      failures++;
      $display("FAIL abort_second: got %h level=%0d required a7f9/0",
               rx, fifo_level);
    end
  endtask

  task automatic test_flush();
    logic [15:0] rx;
    do_reset();
    for (int i = 0; i < 9; i++) push(4'd1, 7'd2);
    repeat (4) @(negedge clk);
    spi_xfer(16'hFFFF, 16, 1'b0, rx);
    checks++;
    if (fifo_level !== 4'd0 || overflow_led !== 1'b0 || mcu_done !== 1'b0) begin
      failures++;
      $display("FAIL flush: level=%0d led=%b done=%b required 0/0/0",
               fifo_level, overflow_led, mcu_done);
    end
    push(4'd4, 7'd64);
    repeat (4) @(negedge clk);
    spi_xfer(16'h0000, 16, 1'b0, rx);
    checks++;
    if (rx !== 16'h9200) begin
      failures++;
      $display("FAIL flush_next: got %h required 9200", rx);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] rx;
    do_reset();
    for (int i = 0; i < 8; i++) push(4'd6, 7'd3);
    repeat (4) @(negedge clk);
    trig_drum_id = 4'd6;
    trig_velocity = 7'd3;
    spi_xfer(16'h0000, 16, 1'b1, rx);
    checks++;
    if (rx !== 16'h9818) begin
      failures++;
      $display("FAIL b2b_frame: got %h required 9818", rx);
    end
    checks++;
    if (fifo_level !== 4'd8 || overflow_led !== 1'b0) begin
      failures++;
      $display("FAIL b2b_full: level=%0d led=%b required 8/0",
               fifo_level, overflow_led);
    end
  endtask

  task automatic test_reset_mid_shift();
    logic [15:0] rx;
    do_reset();
    push(4'hF, 7'h7F);
    repeat (4) @(negedge clk);
    mcu_load = 1'b1;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      repeat (4) @(negedge clk);
      mcu_sck = 1'b1;
      repeat (4) @(negedge clk);
      mcu_sck = 1'b0;
    end
    repeat (4) @(negedge clk);
    checks++;
    if (mcu_sdo !== 1'b1 || mcu_done !== 1'b1 || fifo_level !== 4'd1) begin
      failures++;
      $display("FAIL mid_shift: sdo=%b done=%b level=%0d required 1/1/1",
               mcu_sdo, mcu_done, fifo_level);
    end
    fpga_rst_n = 1'b0;
    #1;
    checks++;
    if ({mcu_sdo, mcu_done, overflow_led} !== 3'b000 || fifo_level !== 4'd0) begin
      failures++;
      $display("FAIL async_reset: sdo=%b done=%b led=%b level=%0d required 0",
               mcu_sdo, mcu_done, overflow_led, fifo_level);
    end
    do_reset();
    push(4'd1, 7'd1);
    repeat (4) @(negedge clk);
    spi_xfer(16'h0000, 16, 1'b0, rx);
    checks++;
    if (rx !== 16'h8408) begin
      failures++;
      $display("FAIL post_reset: got %h required 8408", rx);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_event();
    test_overflow();
    test_empty_read();
    test_abort();
    test_flush();
    test_back_to_back();
    test_reset_mid_shift();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
